vga_fb_apb: RTL and testbench

VGA_FB_APB -- requirements
Module: vga_fb_apb

---
 rtl/vga_fb_apb.sv | 174 +++++++++++++++++
 tb/tb_vga_fb_apb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_apb.sv
// VGA scan-out of a 24-bit framebuffer, with an APB slave giving access to
// pixel memory and to the control/status registers.
module vga_fb_apb #(
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int FB_AW  = 19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_valid,
    output logic        irq
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACT);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);

    logic [HW-1:0]    hc;
    logic [VW-1:0]    vc;
    logic [FB_AW-1:0] pa;
    logic [1:0]       ctrl;
    logic             frame;
    logic [31:0]      frame_cnt;
    logic             hs_q, vs_q, valid_q;
    logic [23:0]      pix_q;
    logic [23:0]      fb [2**FB_AW];
    logic [23:0]      fb_rd_q;
    logic [31:0]      reg_rd_q;
    logic             sel_reg_q;
    logic             pready_q;

    logic             en, h_act, v_act, active, frame_end;
    logic             access, done, is_reg, reg_wr, fb_wr;
    logic [FB_AW-1:0] fb_idx;
    logic [1:0]       reg_idx;
    logic [31:0]      reg_val;
    logic             unused_bits;

    assign en        = ctrl[0];
    assign h_act     = (hc >= H_ACT_BEG) && (hc < H_ACT_END);
    assign v_act     = (vc >= V_ACT_BEG) && (vc < V_ACT_END);
    assign active    = en && h_act && v_act;
    assign frame_end = en && (hc == H_LAST) && (vc == V_LAST);

    assign access  = in_psel & in_penable;
    assign done    = access & pready_q;
    assign is_reg  = in_paddr[23];
    assign fb_idx  = in_paddr[FB_AW+1:2];
    assign reg_idx = in_paddr[3:2];
    assign reg_wr  = done & in_pwrite & is_reg & in_pstrb[0];
    assign fb_wr   = done & in_pwrite & ~is_reg & ~reset;

    assign unused_bits = ^{in_pprot, in_paddr[31:24], in_paddr[22:FB_AW+2],
                           in_paddr[1:0], in_pwdata[31:24], in_pstrb[3]};

    always_comb begin
        reg_val = '0;
        case (reg_idx)
            2'd0:    reg_val = {30'd0, ctrl};
            2'd1:    reg_val = {30'd0, frame, ~v_act};
            2'd2:    reg_val = {16'(V_ACT), 16'(H_ACT)};
            default: reg_val = frame_cnt;
        endcase
    end

    // Sync/valid pass through one register so they line up with the fb read.
    always_ff @(posedge clock) begin
        if (reset) begin
            hc      <= '0;
            vc      <= '0;
            pa      <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            hs_q    <= ~(en && (hc < H_SYNC_END));
            vs_q    <= ~(en && (vc < V_SYNC_END));
            valid_q <= active;
            if (!en) begin
                hc <= '0;
                vc <= '0;
                pa <= '0;
            end else begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
                if (frame_end)
                    pa <= '0;
                else if (active)
                    pa <= pa + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        pix_q   <= fb[pa];
        fb_rd_q <= fb[fb_idx];
        if (fb_wr) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (in_pstrb[i])
                    fb[fb_idx][8*i +: 8] <= in_pwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pready_q  <= 1'b0;
            sel_reg_q <= 1'b0;
            reg_rd_q  <= '0;
            ctrl      <= '0;
            frame     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pready_q  <= access & ~pready_q;
            sel_reg_q <= is_reg;
            reg_rd_q  <= reg_val;
            if (reg_wr && reg_idx == 2'd0)
                ctrl <= in_pwdata[1:0];
            // A frame-end set takes priority over a coincident clear.
            if (frame_end)
                frame <= 1'b1;
            else if (reg_wr && reg_idx == 2'd1 && in_pwdata[1])
                frame <= 1'b0;
            if (frame_end)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

    assign in_pready  = pready_q;
    assign in_prdata  = pready_q ? (sel_reg_q ? reg_rd_q : {8'd0, fb_rd_q}) : '0;
    assign in_pslverr = 1'b0;
    assign vga_hsync  = hs_q;
    assign vga_vsync  = vs_q;
    assign vga_valid  = valid_q;
    assign vga_r      = valid_q ? pix_q[23:16] : '0;
    assign vga_g      = valid_q ? pix_q[15:8]  : '0;
    assign vga_b      = valid_q ? pix_q[7:0]   : '0;
    assign irq        = frame & ctrl[1];

endmodule

// File: tb/tb_vga_fb_apb.sv
// Bench for vga_fb_apb: a small-timing instance for scan/APB behaviour and a
// default-parameter instance for the SIZE register.
module tb_vga_fb_apb;
    localparam int SH = 1, SHB = 1, SHA = 4, SHF = 1;
    localparam int SV = 1, SVB = 1, SVA = 3, SVF = 1;
    localparam int SAW = 6;
    localparam int HT = SH + SHB + SHA + SHF;
    localparam int VT = SV + SVB + SVA + SVF;
    localparam int FT = HT * VT;

    localparam logic [31:0] A_CTRL = 32'h0080_0000;
    localparam logic [31:0] A_STAT = 32'h0080_0004;
    localparam logic [31:0] A_SIZE = 32'h0080_0008;
    localparam logic [31:0] A_FCNT = 32'h0080_000C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel_s = 1'b0, psel_d = 1'b0, penable = 1'b0;
    logic [2:0]  pprot = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    logic        s_pready, s_pslverr, s_hsync, s_vsync, s_valid, s_irq;
    logic [31:0] s_prdata;
    logic [7:0]  s_r, s_g, s_b;
    logic        d_pready, d_pslverr, d_hsync, d_vsync, d_valid, d_irq;
    logic [31:0] d_prdata;
    logic [7:0]  d_r, d_g, d_b;

    always #5 clock = ~clock;

    vga_fb_apb #(.H_SYNC(SH), .H_BP(SHB), .H_ACT(SHA), .H_FP(SHF),
                 .V_SYNC(SV), .V_BP(SVB), .V_ACT(SVA), .V_FP(SVF), .FB_AW(SAW)) u_small (
        .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel_s), .in_penable(penable),
        .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(s_pready), .in_prdata(s_prdata), .in_pslverr(s_pslverr),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hsync(s_hsync), .vga_vsync(s_vsync),
        .vga_valid(s_valid), .irq(s_irq));

    vga_fb_apb u_def (
        .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel_d), .in_penable(penable),
        .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(d_pready), .in_prdata(d_prdata), .in_pslverr(d_pslverr),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hsync(d_hsync), .vga_vsync(d_vsync),
        .vga_valid(d_valid), .irq(d_irq));

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [23:0] fb_m [64];
    logic [31:0] rd_data;
    int last_waits, last_cap, last_commit;
    int c0;

    // Position model: p counts pixel clocks since the enabling write committed.
    function automatic bit m_vblank(input int p);
        int v = (p / HT) % VT;
        return !(v >= SV + SVB && v < SV + SVB + SVA);
    endfunction

    function automatic logic [31:0] fb_addr(input int idx);
        logic [31:0] a = $urandom;
        a[23]  = 1'b0;
        a[7:2] = 6'(idx);
        return a;
    endfunction

    task automatic apb(input bit use_def, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output int waits, output int cap, output int commit);
        logic rdy;
        @(posedge clock); #1;
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; penable = 1'b0;
        pprot = 3'($urandom);
        if (use_def) psel_d = 1'b1; else psel_s = 1'b1;
        @(posedge clock); #1;
        penable = 1'b1;
        waits = 0;
        do begin
            @(posedge clock); #1;
            waits++;
            rdy = use_def ? d_pready : s_pready;
        end while (!rdy && waits < 8);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%h: pready got 0 want 1", addr);
        end
        rdata = use_def ? d_prdata : s_prdata;
        cap = cyc;
        @(posedge clock); #1;
        commit = cyc;
        psel_s = 1'b0; psel_d = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input bit use_def, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        apb(use_def, 1'b1, a, d, st, rd_data, last_waits, last_cap, last_commit);
    endtask

    task automatic rd(input bit use_def, input logic [31:0] a);
        apb(use_def, 1'b0, a, 32'h0, 4'h0, rd_data, last_waits, last_cap, last_commit);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin @(posedge clock); #1; end
    endtask

    task automatic run_scan(input int ncyc, input bit irq_en, input bit frame_pre);
        int hs_lo = 0, vs_lo = 0, nval = 0;
        bit seen = 0;
        logic [23:0] first_rgb = '0;
        for (int k = 0; k < ncyc; k++) begin
            int p, h, v;
            logic e_hs, e_vs, e_val, e_irq;
            logic [23:0] e_rgb;
            logic [27:0] got, exp;
            @(posedge clock); #1;
            p = cyc - c0 - 1;
            h = p % HT;
            v = (p / HT) % VT;
            e_hs  = (h >= SH);
            e_vs  = (v >= SV);
            e_val = (h >= SH + SHB) && (h < SH + SHB + SHA) && (v >= SV + SVB) && (v < SV + SVB + SVA);
            e_rgb = e_val ? fb_m[(v - SV - SVB) * SHA + (h - SH - SHB)] : 24'h0;
            e_irq = irq_en && (frame_pre || (cyc - c0) >= FT);
            got = {s_hsync, s_vsync, s_valid, s_irq, s_r, s_g, s_b};
            exp = {e_hs, e_vs, e_val, e_irq, e_rgb};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL scan p=%0d: got %h want %h", p, got, exp);
            end
            if (!s_hsync) hs_lo++;
            if (!s_vsync) vs_lo++;
            if (s_valid) begin
                nval++;
                if (!seen) begin seen = 1; first_rgb = {s_r, s_g, s_b}; end
            end
        end
        checks++;
        if (hs_lo !== ncyc / HT) begin errors++; $display("FAIL hsync_low_count: got %0d want %0d", hs_lo, ncyc / HT); end
        checks++;
        if (vs_lo !== SV * HT * (ncyc / FT)) begin errors++; $display("FAIL vsync_low_count: got %0d want %0d", vs_lo, SV * HT * (ncyc / FT)); end
        checks++;
        if (nval !== SHA * SVA * (ncyc / FT)) begin errors++; $display("FAIL valid_count: got %0d want %0d", nval, SHA * SVA * (ncyc / FT)); end
        checks++;
        if (first_rgb !== fb_m[0]) begin errors++; $display("FAIL first_pixel: got %h want %h", first_rgb, fb_m[0]); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({s_hsync, s_vsync, s_valid, s_irq, s_r, s_g, s_b, s_pready, s_prdata, s_pslverr} !== {4'b1100, 24'h0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got hs=%b vs=%b val=%b irq=%b rgb=%h rdy=%b prdata=%h want 1 1 0 0 0 0 0",
                     s_hsync, s_vsync, s_valid, s_irq, {s_r, s_g, s_b}, s_pready, s_prdata);
        end
        reset = 1'b0;
        rd(0, A_CTRL);
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rd_data); end
        rd(0, A_STAT);
        checks++;
        if (rd_data !== 32'h1) begin errors++; $display("FAIL reset_status: got %h want 1", rd_data); end
        rd(0, A_FCNT);
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_fcnt: got %h want 0", rd_data); end
    endtask

    task automatic test_fb_bytelane();
        wr(0, 32'h0000_0004, 32'h00AA_BBCC, 4'b0111);
        checks++;
        if (last_waits !== 1) begin errors++; $display("FAIL fb_wait_state: got %0d want 1", last_waits); end
        rd(0, 32'h0000_0004);
        checks++;
        if (rd_data !== 32'h00AA_BBCC) begin errors++; $display("FAIL fb_read1: got %h want 00aabbcc", rd_data); end
        wr(0, 32'h0000_0004, 32'h1122_3344, 4'b0001);
        rd(0, 32'h0000_0004);
        checks++;
        if (rd_data !== 32'h00AA_BB44) begin errors++; $display("FAIL fb_read2: got %h want 00aabb44", rd_data); end

        for (int i = 0; i < 64; i++) begin
            fb_m[i] = 24'($urandom);
            wr(0, fb_addr(i), {8'($urandom), fb_m[i]}, 4'b1111);
        end
        for (int n = 0; n < 40; n++) begin
            int idx = $urandom_range(63);
            logic [31:0] d = $urandom;
            logic [3:0] st = 4'($urandom);
            for (int l = 0; l < 3; l++)
                if (st[l]) fb_m[idx][8*l +: 8] = d[8*l +: 8];
            wr(0, fb_addr(idx), d, st);
        end
        for (int n = 0; n < 16; n++) begin
            int idx = $urandom_range(63);
            rd(0, fb_addr(idx));
            checks++;
            if (rd_data !== {8'h0, fb_m[idx]}) begin
                errors++;
                $display("FAIL fb_random idx=%0d: got %h want %h", idx, rd_data, {8'h0, fb_m[idx]});
            end
        end
    endtask

    task automatic test_size();
        rd(1, A_SIZE);
        checks++;
        if (rd_data !== 32'h01E0_0280) begin errors++; $display("FAIL size_default: got %h want 01e00280", rd_data); end
        rd(0, A_SIZE);
        checks++;
        if (rd_data !== {16'(SVA), 16'(SHA)}) begin errors++; $display("FAIL size_small: got %h want %h", rd_data, {16'(SVA), 16'(SHA)}); end
        wr(1, 32'h001F_FFFC, 32'hFF5A_6B7C, 4'b1111);
        rd(1, 32'h001F_FFFC);
        checks++;
        if (rd_data !== 32'h005A_6B7C) begin errors++; $display("FAIL fb_default_top: got %h want 005a6b7c", rd_data); end
        checks++;
        if ({d_hsync, d_vsync, d_valid, d_irq, d_r, d_g, d_b, d_pslverr} !== {4'b1100, 24'h0, 1'b0}) begin
            errors++;
            $display("FAIL default_idle: got %b want 1100 rgb 0 err 0", {d_hsync, d_vsync, d_valid, d_irq});
        end
    endtask

    task automatic test_timing();
        for (int i = 0; i < SHA * SVA; i++) begin
            fb_m[i] = (i == 0) ? 24'h123456 : 24'($urandom);
            wr(0, fb_addr(i), {8'h0, fb_m[i]}, 4'b0111);
        end
        wr(0, A_CTRL, 32'h3, 4'b0001);
        c0 = last_commit;
        run_scan(2 * FT, 1'b1, 1'b0);
    endtask

    task automatic test_frame_irq();
        int target;
        rd(0, A_FCNT);
        checks++;
        if (rd_data !== 32'((last_cap - c0 - 1) / FT)) begin
            errors++; $display("FAIL frame_cnt: got %0d want %0d", rd_data, (last_cap - c0 - 1) / FT);
        end
        checks++;
        if (s_irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", s_irq); end
        wr(0, A_STAT, 32'h2, 4'b0001);
        checks++;
        if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", s_irq); end

        // Land the W1C commit exactly on the next frame-end edge.
        target = c0 + FT * ((cyc - c0 + 4) / FT + 1);
        wait_cyc(target - 4);
        wr(0, A_STAT, 32'h2, 4'b0001);
        checks++;
        if (s_irq !== 1'b1 || last_commit !== target) begin
            errors++; $display("FAIL w1c_vs_set: got irq=%b at %0d want 1 at %0d", s_irq, last_commit, target);
        end
        rd(0, A_STAT);
        checks++;
        if (rd_data !== {30'h0, 1'b1, m_vblank(last_cap - c0 - 1)}) begin
            errors++; $display("FAIL status_after_w1c: got %h want %h", rd_data, {30'h0, 1'b1, m_vblank(last_cap - c0 - 1)});
        end
    endtask

    task automatic test_disable();
        int target, fc_frozen;
        target = c0 + FT * ((cyc - c0 + 4) / FT + 1) + (SV + SVB + 1) * HT + SH + SHB + 2;
        wait_cyc(target - 4);
        wr(0, A_CTRL, 32'h0, 4'b0001);
        fc_frozen = (last_commit - c0) / FT;
        @(posedge clock); #1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            checks++;
            if ({s_hsync, s_vsync, s_valid, s_irq, s_r, s_g, s_b} !== {4'b1100, 24'h0}) begin
                errors++;
                $display("FAIL disabled_idle k=%0d: got %b rgb=%h want 1100 rgb 0", k, {s_hsync, s_vsync, s_valid, s_irq}, {s_r, s_g, s_b});
            end
        end
        rd(0, A_STAT);
        checks++;
        if (rd_data !== 32'h3) begin errors++; $display("FAIL disabled_status: got %h want 3", rd_data); end
        rd(0, A_FCNT);
        checks++;
        if (rd_data !== 32'(fc_frozen)) begin errors++; $display("FAIL disabled_fcnt: got %0d want %0d", rd_data, fc_frozen); end

        wr(0, A_CTRL, 32'h1, 4'b0001);
        c0 = last_commit;
        run_scan(FT, 1'b0, 1'b1);
        rd(0, A_FCNT);
        checks++;
        if (rd_data !== 32'(fc_frozen + (last_cap - c0 - 1) / FT)) begin
            errors++; $display("FAIL reenable_fcnt: got %0d want %0d", rd_data, fc_frozen + (last_cap - c0 - 1) / FT);
        end
    endtask

    task automatic test_reset_abort();
        fb_m[9] = 24'($urandom);
        wr(0, fb_addr(9), {8'h0, fb_m[9]}, 4'b0111);
        @(posedge clock); #1;
        paddr = fb_addr(9); pwrite = 1'b1; pwdata = {8'h0, ~fb_m[9]}; pstrb = 4'b1111; psel_s = 1'b1;
        @(posedge clock); #1;
        penable = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (s_pready !== 1'b1) begin errors++; $display("FAIL abort_setup_pready: got %b want 1", s_pready); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (s_pready !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b want 0", s_pready); end
        reset = 1'b0; psel_s = 1'b0; penable = 1'b0;
        rd(0, fb_addr(9));
        checks++;
        if (rd_data !== {8'h0, fb_m[9]}) begin errors++; $display("FAIL abort_word: got %h want %h", rd_data, {8'h0, fb_m[9]}); end
    endtask

    initial begin
        test_reset();
        test_fb_bytelane();
        test_size();
        test_timing();
        test_frame_irq();
        test_disable();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
